// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the instruction/data RAM arbiter.
//   arb_state_t : arbiter FSM state
//   grant_t     : which requester owned the most recent access
//   RAM_LAT_DEFAULT : default RAM read latency in cycles
//   lat_cnt_w() : width of the in-access latency counter
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      IACC,
      DACC,
      IRESP,
      DRESP
   } arb_state_t;

   typedef enum logic {
      INSTR,
      DATA
   } grant_t;

   localparam int RAM_LAT_DEFAULT = 2;

   // A one-cycle RAM still needs a 1-bit counter to keep the vector legal.
   function automatic int lat_cnt_w(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two requester ports and the RAM port of the arbiter.
//   instruction port : iren, iaddr -> iready, iload
//   data port        : dren, dwen, daddr, dstore -> dready, dload
//   RAM port         : ram_ren, ram_wen, ram_addr, ram_store <- ram_load
// Modports:
//   slave  : the arbiter
//   master : everything around it (core datapath and RAM wrapper)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              iren;
   logic [ADDR_W-1:0] iaddr;
   logic              iready;
   logic [DATA_W-1:0] iload;

   logic              dren;
   logic              dwen;
   logic [ADDR_W-1:0] daddr;
   logic [DATA_W-1:0] dstore;
   logic              dready;
   logic [DATA_W-1:0] dload;

   logic              ram_ren;
   logic              ram_wen;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_store;
   logic [DATA_W-1:0] ram_load;

   modport slave (
      input  iren, iaddr, dren, dwen, daddr, dstore, ram_load,
      output iready, iload, dready, dload, ram_ren, ram_wen, ram_addr, ram_store
   );

   modport master (
      output iren, iaddr, dren, dwen, daddr, dstore, ram_load,
      input  iready, iload, dready, dload, ram_ren, ram_wen, ram_addr, ram_store
   );

endinterface

// File: rtl/mem_arbiter_sat_cnt.sv
// ---------------------------------------------------------------------------
// mem_arb_sat_cnt
// 32-bit event counter that sticks at all-ones instead of wrapping.
//   clk   : system clock
//   nRST  : asynchronous active-low reset, clears the count
//   en    : count this cycle
//   count : current value
// ---------------------------------------------------------------------------
module mem_arb_sat_cnt (
   input  logic        clk,
   input  logic        nRST,
   input  logic        en,
   output logic [31:0] count
);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         count <= '0;
      end else if (en && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port RAM between the instruction fetch and the data
// load/store requesters. Each access holds the RAM for RAM_LAT cycles, then
// the owner gets a one-cycle ready pulse with the (registered) read data.
// When both sides are waiting the grant alternates so neither starves.
//
// Ports:
//   clk   : system clock
//   nRST  : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave, requester and RAM signals
//   perf_istall / perf_dstall / perf_conflict : saturating event counters,
//           present only when MEM_ARB_PERF_EN is defined
//
// Build option: MEM_ARB_PERF_EN adds the three performance counters.
//
// state | meaning
// IDLE  | RAM idle, picks the next requester
// IACC  | instruction read in progress, RAM_LAT cycles
// DACC  | data read or write in progress, RAM_LAT cycles
// IRESP | iready pulse, result in iload
// DRESP | dready pulse, result in dload (reads only)
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int RAM_LAT = RAM_LAT_DEFAULT   // must be >= 1
) (
   input  logic         clk,
   input  logic         nRST,
   mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]  perf_istall,
   output logic [31:0]  perf_dstall,
   output logic [31:0]  perf_conflict
`endif
);

   localparam int               CNT_W    = lat_cnt_w(RAM_LAT);
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RAM_LAT - 1);

   arb_state_t        state;
   grant_t            last_grant;
   logic [CNT_W-1:0]  lat_cnt;
   logic              d_write;

   logic              iready_q;
   logic              dready_q;
   logic              ram_ren_q;
   logic              ram_wen_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_store_q;
   logic [DATA_W-1:0] iload_q;
   logic [DATA_W-1:0] dload_q;

   logic              d_pend;
   logic              take_data;
   logic              unused_addr_lsbs;

   assign d_pend    = bus.dren | bus.dwen;
   // Data wins when it is alone, or when both wait and instruction went last.
   assign take_data = d_pend & (~bus.iren | (last_grant == INSTR));

   // RAM is word addressed; byte offsets are dropped.
   assign unused_addr_lsbs = ^{bus.iaddr[1:0], bus.daddr[1:0]};

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state       <= IDLE;
         last_grant  <= INSTR;
         lat_cnt     <= '0;
         d_write     <= 1'b0;
         iready_q    <= 1'b0;
         dready_q    <= 1'b0;
         ram_ren_q   <= 1'b0;
         ram_wen_q   <= 1'b0;
         ram_addr_q  <= '0;
         ram_store_q <= '0;
         iload_q     <= '0;
         dload_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               lat_cnt <= '0;
               // ram_addr/ram_store double as the latched operands for the access.
               if (take_data) begin
                  state      <= DACC;
                  d_write    <= bus.dwen;
                  ram_addr_q <= {bus.daddr[ADDR_W-1:2], 2'b00};
                  ram_ren_q  <= ~bus.dwen;
                  ram_wen_q  <= bus.dwen;
                  if (bus.dwen) begin
                     ram_store_q <= bus.dstore;
                  end
               end else if (bus.iren) begin
                  state      <= IACC;
                  ram_addr_q <= {bus.iaddr[ADDR_W-1:2], 2'b00};
                  ram_ren_q  <= 1'b1;
               end
            end

            IACC: begin
               if (lat_cnt == LAT_LAST) begin
                  iload_q    <= bus.ram_load;
                  ram_ren_q  <= 1'b0;
                  last_grant <= INSTR;
                  iready_q   <= 1'b1;
                  lat_cnt    <= '0;
                  state      <= IRESP;
               end else begin
                  lat_cnt <= lat_cnt + CNT_W'(1);
               end
            end

            DACC: begin
               if (lat_cnt == LAT_LAST) begin
                  if (!d_write) begin
                     dload_q <= bus.ram_load;
                  end
                  ram_ren_q  <= 1'b0;
                  ram_wen_q  <= 1'b0;
                  last_grant <= DATA;
                  dready_q   <= 1'b1;
                  lat_cnt    <= '0;
                  state      <= DRESP;
               end else begin
                  lat_cnt <= lat_cnt + CNT_W'(1);
               end
            end

            IRESP: begin
               iready_q <= 1'b0;
               state    <= IDLE;
            end

            DRESP: begin
               dready_q <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               iready_q  <= 1'b0;
               dready_q  <= 1'b0;
               ram_ren_q <= 1'b0;
               ram_wen_q <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.iready    = iready_q;
   assign bus.dready    = dready_q;
   assign bus.iload     = iload_q;
   assign bus.dload     = dload_q;
   assign bus.ram_ren   = ram_ren_q;
   assign bus.ram_wen   = ram_wen_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_store = ram_store_q;

`ifdef MEM_ARB_PERF_EN
   mem_arb_sat_cnt u_istall (
      .clk   (clk),
      .nRST  (nRST),
      .en    (bus.iren & ~iready_q),
      .count (perf_istall)
   );

   mem_arb_sat_cnt u_dstall (
      .clk   (clk),
      .nRST  (nRST),
      .en    (d_pend & ~dready_q),
      .count (perf_dstall)
   );

   mem_arb_sat_cnt u_conflict (
      .clk   (clk),
      .nRST  (nRST),
      .en    ((state == IDLE) & bus.iren & d_pend),
      .count (perf_conflict)
   );
`endif

endmodule
